// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the PC sequencer and the hazard, branch and debug logic.
interface pc_sequencer_if #(
    parameter int unsigned PC_WIDTH = 32
) ();
    logic                start;
    logic                step_mode;
    logic                step;
    logic                stall;
    logic                branch_taken;
    logic [PC_WIDTH-1:0] branch_target;
    logic                jump;
    logic [PC_WIDTH-1:0] jump_target;
    logic                halt_fetched;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_next_seq;
    logic                pc_en;
    logic                flush;
    logic                halted;
    logic [31:0]         cycle_count;

    // Controller side: debug unit, hazard unit, branch/jump resolution.
    modport master (
        output start, step_mode, step, stall, branch_taken, branch_target,
               jump, jump_target, halt_fetched,
        input  pc, pc_next_seq, pc_en, flush, halted, cycle_count
    );

    // Sequencer side.
    modport slave (
        input  start, step_mode, step, stall, branch_taken, branch_target,
               jump, jump_target, halt_fetched,
        output pc, pc_next_seq, pc_en, flush, halted, cycle_count
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, gates pipeline advance for the debug unit,
// and drains the pipeline after a HALT fetch before reporting halted.
module pc_sequencer #(
    parameter int unsigned         PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = '0,
    parameter int unsigned         DRAIN_CYCLES = 4
) (
    input logic           clk,
    input logic           reset,
    pc_sequencer_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StRun, StStep, StDrain, StHalted} state_e;

    localparam logic [3:0]          DrainLast = 4'(DRAIN_CYCLES);
    localparam logic [PC_WIDTH-1:0] PcOne     = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                mode_step_q, mode_step_d;
    logic [3:0]          drain_cnt_q, drain_cnt_d;
    logic [31:0]         cycle_count_q, cycle_count_d;

    logic                adv;
    logic                redirect;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic [PC_WIDTH-1:0] pc_inc;

    assign pc_inc      = pc_q + PcOne;
    assign redirect    = adv & (bus.branch_taken | bus.jump);
    // Branch outranks jump when both resolve in the same cycle.
    assign redirect_pc = bus.branch_taken ? bus.branch_target : bus.jump_target;

    // State register; synchronous reset beats every other input at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            mode_step_q   <= 1'b0;
            drain_cnt_q   <= '0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            mode_step_q   <= mode_step_d;
            drain_cnt_q   <= drain_cnt_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    // Advance qualification, PC selection and next-state decode.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        mode_step_d   = mode_step_q;
        drain_cnt_d   = drain_cnt_q;
        cycle_count_d = cycle_count_q;
        adv           = 1'b0;

        unique case (state_q)
            StRun:   adv = 1'b1;
            StStep:  adv = bus.step;
            StDrain: adv = mode_step_q ? bus.step : 1'b1;
            default: adv = 1'b0;
        endcase

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    mode_step_d = bus.step_mode;
                    state_d     = bus.step_mode ? StStep : StRun;
                end
            end
            StRun, StStep: begin
                if (adv) begin
                    if (redirect) begin
                        pc_d = redirect_pc;
                    end else if (bus.stall) begin
                        pc_d = pc_q;
                    end else if (bus.halt_fetched) begin
                        // PC stays on the HALT word while older instructions retire.
                        state_d     = StDrain;
                        drain_cnt_d = '0;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            StDrain: begin
                if (adv) begin
                    if (redirect) begin
                        // An older instruction redirected: HALT was on a dead path.
                        pc_d        = redirect_pc;
                        drain_cnt_d = '0;
                        state_d     = mode_step_q ? StStep : StRun;
                    end else begin
                        drain_cnt_d = drain_cnt_q + 4'd1;
                        if (drain_cnt_q + 4'd1 == DrainLast) begin
                            state_d = StHalted;
                        end
                    end
                end
            end
            default: ;
        endcase

        if (adv && (cycle_count_q != 32'hFFFF_FFFF)) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_next_seq = pc_inc;
    assign bus.pc_en       = adv;
    assign bus.flush       = redirect;
    assign bus.halted      = (state_q == StHalted);
    assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, then random stimulus
// compared against a phase-level reference model.
module tb_pc_sequencer;

    localparam int unsigned DRAIN = 4;

    typedef struct {
        logic        rst, start, sm, step, stall, bt;
        logic [31:0] btgt;
        logic        j;
        logic [31:0] jtgt;
        logic        halt;
        logic [31:0] e_pc, e_nseq, e_cc;
        logic        e_en, e_fl, e_hlt;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    pc_sequencer_if #(.PC_WIDTH(32)) bus ();

    pc_sequencer #(
        .PC_WIDTH    (32),
        .RESET_PC    (32'h0),
        .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    vec_t tbl[$];

    // Reference model: 0 idle, 1 fetching, 2 draining, 3 halted.
    logic [31:0] m_pc;
    longint      m_cc;
    int          m_phase;
    bit          m_sm;
    int          m_drain;

    function automatic bit m_adv(input vec_t v);
        return (m_phase == 1 || m_phase == 2) && (!m_sm || v.step);
    endfunction

    task automatic m_update(input vec_t v);
        bit a;
        a = m_adv(v);
        if (v.rst) begin
            m_pc = 0; m_cc = 0; m_phase = 0; m_sm = 0; m_drain = 0;
        end else if (m_phase == 0) begin
            if (v.start) begin
                m_sm    = v.sm;
                m_phase = 1;
            end
        end else if (a) begin
            if (m_cc < 64'hFFFF_FFFF) m_cc++;
            if (v.bt) begin
                m_pc = v.btgt; m_phase = 1;
            end else if (v.j) begin
                m_pc = v.jtgt; m_phase = 1;
            end else if (m_phase == 2) begin
                m_drain++;
                if (m_drain == DRAIN) m_phase = 3;
            end else if (v.stall) begin
                m_pc = m_pc;
            end else if (v.halt) begin
                m_phase = 2; m_drain = 0;
            end else begin
                m_pc = m_pc + 32'd1;
            end
        end
    endtask

    function automatic void row(input logic rst, start, sm, step, stall, bt,
                                input logic [31:0] btgt, input logic j,
                                input logic [31:0] jtgt, input logic halt,
                                input logic [31:0] pc, input logic en, fl, hlt,
                                input logic [31:0] cc);
        vec_t v;
        v.rst = rst; v.start = start; v.sm = sm; v.step = step; v.stall = stall;
        v.bt = bt; v.btgt = btgt; v.j = j; v.jtgt = jtgt; v.halt = halt;
        v.e_pc = pc; v.e_nseq = pc + 32'd1; v.e_en = en; v.e_fl = fl; v.e_hlt = hlt;
        v.e_cc = cc;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string tag, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %h expected %h", tag, name, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the edge, compare mid-cycle, then let the edge land.
    task automatic run_vec(input vec_t v, input string tag);
        reset            = v.rst;
        bus.start        = v.start;
        bus.step_mode    = v.sm;
        bus.step         = v.step;
        bus.stall        = v.stall;
        bus.branch_taken = v.bt;
        bus.branch_target = v.btgt;
        bus.jump         = v.j;
        bus.jump_target  = v.jtgt;
        bus.halt_fetched = v.halt;
        #3;
        n_vec++;
        chk(tag, "pc", bus.pc, v.e_pc);
        chk(tag, "cycle_count", bus.cycle_count, v.e_cc);
        chk(tag, "halted", 32'(bus.halted), 32'(v.e_hlt));
        if (!v.rst) begin
            chk(tag, "pc_en", 32'(bus.pc_en), 32'(v.e_en));
            chk(tag, "flush", 32'(bus.flush), 32'(v.e_fl));
            chk(tag, "pc_next_seq", bus.pc_next_seq, v.e_nseq);
        end
        m_update(v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        reset = 1'b1;
        bus.start = 0; bus.step_mode = 0; bus.step = 0; bus.stall = 0;
        bus.branch_taken = 0; bus.branch_target = 0; bus.jump = 0; bus.jump_target = 0;
        bus.halt_fetched = 0;
        m_pc = 0; m_cc = 0; m_phase = 0; m_sm = 0; m_drain = 0;
        repeat (2) @(posedge clk);
        #1;

        //  rst st sm sp sl bt btgt   j  jtgt          h   pc            en fl hl cc
        // free run, branch+jump collision, wrap, stall, HALT drain with stall
        row(0, 0, 0, 0, 0, 0, 0,     0, 0,            0,  32'h0,        0, 0, 0, 0);
        row(0, 1, 0, 0, 0, 0, 0,     0, 0,            0,  32'h0,        0, 0, 0, 0);
        row(0, 0, 0, 0, 0, 0, 0,     0, 0,            0,  32'h0,        1, 0, 0, 0);
        row(0, 0, 0, 0, 0, 0, 0,     0, 0,            0,  32'h1,        1, 0, 0, 1);
        row(0, 0, 0, 0, 0, 0, 0,     0, 0,            0,  32'h2,        1, 0, 0, 2);
        row(0, 0, 0, 0, 0, 0, 0,     0, 0,            0,  32'h3,        1, 0, 0, 3);
        row(0, 0, 0, 0, 0, 0, 0,     0, 0,            0,  32'h4,        1, 0, 0, 4);
        row(0, 0, 0, 0, 0, 1, 'h40,  1, 'h80,         0,  32'h5,        1, 1, 0, 5);
        row(0, 0, 0, 0, 0, 0, 0,     0, 0,            0,  32'h40,       1, 0, 0, 6);
        row(0, 0, 0, 0, 0, 0, 0,     1, 'hFFFF_FFFF,  0,  32'h41,       1, 1, 0, 7);
        row(0, 0, 0, 0, 0, 0, 0,     0, 0,            0,  32'hFFFF_FFFF, 1, 0, 0, 8);
        row(0, 0, 0, 0, 0, 0, 0,     0, 0,            0,  32'h0,        1, 0, 0, 9);
        row(0, 0, 0, 0, 1, 0, 0,     0, 0,            0,  32'h1,        1, 0, 0, 10);
        row(0, 0, 0, 0, 0, 0, 0,     0, 0,            0,  32'h1,        1, 0, 0, 11);
        row(0, 0, 0, 0, 0, 0, 0,     1, 'h7,          0,  32'h2,        1, 1, 0, 12);
        row(0, 0, 0, 0, 0, 0, 0,     0, 0,            1,  32'h7,        1, 0, 0, 13);
        row(0, 0, 0, 0, 1, 0, 0,     0, 0,            0,  32'h7,        1, 0, 0, 14);
        row(0, 0, 0, 0, 0, 0, 0,     0, 0,            0,  32'h7,        1, 0, 0, 15);
        row(0, 0, 0, 0, 0, 0, 0,     0, 0,            0,  32'h7,        1, 0, 0, 16);
        row(0, 0, 0, 0, 0, 0, 0,     0, 0,            0,  32'h7,        1, 0, 0, 17);
        row(0, 0, 0, 1, 0, 1, 'h99,  0, 0,            0,  32'h7,        0, 0, 1, 18);
        row(0, 1, 0, 1, 0, 0, 0,     1, 'h55,         0,  32'h7,        0, 0, 1, 18);
        row(1, 0, 0, 0, 0, 0, 0,     0, 0,            0,  32'h7,        0, 0, 1, 18);
        // single-step mode, then drain cancelled by a branch (step mode)
        row(0, 0, 0, 0, 0, 0, 0,     0, 0,            0,  32'h0,        0, 0, 0, 0);
        row(0, 1, 1, 0, 0, 0, 0,     0, 0,            0,  32'h0,        0, 0, 0, 0);
        row(0, 0, 0, 0, 0, 0, 0,     0, 0,            0,  32'h0,        0, 0, 0, 0);
        row(0, 0, 0, 0, 0, 1, 'h10,  0, 0,            0,  32'h0,        0, 0, 0, 0);
        row(0, 0, 0, 0, 0, 0, 0,     0, 0,            0,  32'h0,        0, 0, 0, 0);
        row(0, 0, 0, 1, 0, 0, 0,     0, 0,            0,  32'h0,        1, 0, 0, 0);
        row(0, 0, 0, 0, 0, 0, 0,     0, 0,            0,  32'h1,        0, 0, 0, 1);
        row(0, 0, 0, 1, 0, 0, 0,     0, 0,            0,  32'h1,        1, 0, 0, 1);
        row(0, 0, 0, 1, 0, 0, 0,     0, 0,            0,  32'h2,        1, 0, 0, 2);
        row(0, 0, 0, 0, 0, 0, 0,     0, 0,            0,  32'h3,        0, 0, 0, 3);
        row(0, 0, 0, 1, 0, 0, 0,     0, 0,            1,  32'h3,        1, 0, 0, 3);
        row(0, 0, 0, 1, 0, 0, 0,     0, 0,            0,  32'h3,        1, 0, 0, 4);
        row(0, 0, 0, 0, 0, 0, 0,     0, 0,            0,  32'h3,        0, 0, 0, 5);
        row(0, 0, 0, 1, 0, 1, 'h20,  0, 0,            0,  32'h3,        1, 1, 0, 5);
        row(0, 0, 0, 0, 0, 0, 0,     0, 0,            0,  32'h20,       0, 0, 0, 6);
        row(0, 0, 0, 1, 0, 0, 0,     0, 0,            0,  32'h20,       1, 0, 0, 6);
        row(0, 0, 0, 1, 0, 0, 0,     0, 0,            1,  32'h21,       1, 0, 0, 7);
        row(1, 0, 0, 0, 0, 0, 0,     0, 0,            0,  32'h21,       0, 0, 0, 8);
        // free-run drain cancelled by a branch on the second drain advance
        row(0, 1, 0, 0, 0, 0, 0,     0, 0,            0,  32'h0,        0, 0, 0, 0);
        row(0, 0, 0, 0, 0, 0, 0,     0, 0,            1,  32'h0,        1, 0, 0, 0);
        row(0, 0, 0, 0, 0, 0, 0,     0, 0,            0,  32'h0,        1, 0, 0, 1);
        row(0, 0, 0, 0, 0, 1, 'h20,  0, 0,            0,  32'h0,        1, 1, 0, 2);
        row(0, 0, 0, 0, 0, 0, 0,     0, 0,            0,  32'h20,       1, 0, 0, 3);
        row(0, 0, 0, 0, 0, 0, 0,     0, 0,            0,  32'h21,       1, 0, 0, 4);

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Random stimulus against the reference model.
        for (int i = 0; i < 3000; i++) begin
            v.rst   = (i == 0) || ($urandom_range(0, 99) < 2);
            v.start = ($urandom_range(0, 9) < 2);
            v.sm    = $urandom_range(0, 1);
            v.step  = $urandom_range(0, 1);
            v.stall = ($urandom_range(0, 4) == 0);
            v.bt    = ($urandom_range(0, 99) < 8);
            v.j     = ($urandom_range(0, 99) < 8);
            v.halt  = ($urandom_range(0, 99) < 6);
            v.btgt  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom;
            v.jtgt  = $urandom;
            v.e_pc   = m_pc;
            v.e_nseq = m_pc + 32'd1;
            v.e_cc   = 32'(m_cc);
            v.e_en   = m_adv(v);
            v.e_fl   = m_adv(v) && (v.bt || v.j);
            v.e_hlt  = (m_phase == 3);
            run_vec(v, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the word-addressed MIPS pipeline. Owns the PC register and selects each cycle between sequential fetch (PC+1), branch target, jump target or hold (stall / halt / debug single-step). It gates pipeline advance for the debug unit and drains the pipeline before reporting halt. Sits between the hazard/branch logic (ID/EX) and the IF stage.

## Interface
- PC_WIDTH, 32, width of PC and targets
- RESET_PC, 0, PC value loaded on reset
- DRAIN_CYCLES, 4, pipeline advances allowed after HALT fetch before `halted` asserts (1..15)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; returns block to IDLE
- start  in  1  pulse from debug unit; leaves IDLE (ignored elsewhere)
- step_mode  in  1  sampled only with `start`: 1 = single-step, 0 = free run
- step  in  1  pulse; one pipeline advance in step mode (ignored otherwise)
- stall  in  1  hazard unit: hold PC and IF/ID this cycle
- branch_taken  in  1  branch resolved taken
- branch_target  in  PC_WIDTH  branch destination
- jump  in  1  jump decoded
- jump_target  in  PC_WIDTH  jump destination
- halt_fetched  in  1  instruction at current `pc` is HALT
- pc  out  PC_WIDTH  current fetch address (registered)
- pc_next_seq  out  PC_WIDTH  pc + 1 (combinational)
- pc_en  out  1  pipeline advance enable for all stage registers
- flush  out  1  squash IF/ID this cycle
- halted  out  1  program finished, pipeline drained
- cycle_count  out  32  number of advance cycles since reset

## Operation
- States: IDLE, RUN, STEP, DRAIN, HALTED. Reset → IDLE, pc=RESET_PC, drain counter=0, cycle_count=0, all 1-bit outputs 0.
- IDLE: `start` → STEP if `step_mode` else RUN. No advance.
- adv = (RUN) | (STEP & step) | (DRAIN & mode_run) | (DRAIN & step & mode_step); mode latched at `start`. `pc_en` = adv.
- On adv, PC update priority: branch_taken → branch_target; else jump → jump_target; else stall → hold; else halt_fetched → hold (enter DRAIN); else pc_next_seq.
- `flush` = adv & (branch_taken | jump). Both asserted: branch wins, flush single cycle.
- `stall` with adv: PC held, `pc_en` still 1 (hazard unit bubbles ID/EX), `cycle_count` increments.
- HALT fetch (RUN/STEP, adv, no redirect, no stall): PC frozen at HALT address, state → DRAIN, counter cleared.
- DRAIN: each adv increments counter; when counter reaches DRAIN_CYCLES → HALTED. branch_taken or jump during DRAIN (older instruction redirecting): cancel drain, load target, flush, return to RUN/STEP per latched mode.
- HALTED: `halted`=1, `pc_en`=0, PC held; only reset exits.
- `pc_next_seq` wraps modulo 2^PC_WIDTH (max → 0), no flag.
- `cycle_count` increments on each adv, saturates at 2^32−1.
- Inputs other than reset/start/step_mode ignored in IDLE and HALTED.

## Timing
- PC update visible one cycle after the adv edge; zero-latency combinational `pc_en`, `flush`, `pc_next_seq`.
- `start` to first advance: state changes on edge N; first `pc_en` in cycle N+1 (RUN) or first `step` after N (STEP).
- `step` is edge-qualified by the debug unit; block treats every high cycle as one step.
- `halted` asserts at the edge where the DRAIN_CYCLES-th drain advance completes.
- Reset mid-operation (any state) wins over all inputs at that edge.

## Test plan
- Reset, start with step_mode=0, no events: pc = 0,1,2,3… on successive cycles; pc_en=1; cycle_count=pc.
- RUN at pc=5: branch_taken=1, branch_target=0x40 with jump=1, jump_target=0x80 same cycle → flush=1 one cycle, next pc=0x40.
- step_mode=1: no step for 10 cycles → pc static, pc_en=0; three step pulses → pc advances exactly 3, cycle_count=3.
- HALT at pc=7, DRAIN_CYCLES=4, stall=1 on first drain cycle → pc stays 7, halted asserts after 4th advance, pc_en=0 thereafter.
- DRAIN with branch_taken=1, target=0x20 on second drain advance → no halt, pc=0x20, flush=1, state back to RUN.
- pc=0xFFFFFFFF sequential → pc=0; reset asserted in DRAIN → pc=RESET_PC, halted=0, cycle_count=0, IDLE.
